reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Conditions the raw board reset push-button and the board power-on reset into the clean, active-high system reset `rst` consumed by the CPU, peripherals and bring-up test tops. It sits directly upstream of every block that takes `rst`. Internally it synchronises and debounces the button, then runs a small state machine. The state machine guarantees a minimum reset pulse width, clean synchronous deassertion, and a one-cycle release strobe.

## Interface
- `DEBOUNCE_CYCLES`, 250_000, consecutive stable cycles required to accept a button level change (10 ms at 25 MHz); minimum 1.
- `HOLD_CYCLES`, 2_500, cycles `rst` stays asserted after the last reset cause clears (100 µs); minimum 2.
- `clk_25mhz` input 1: sole clock.
- `rst_n` input 1: board power-on reset. Asynchronous, active-low; deassertion is synchronous to `clk_25mhz` (board POR logic).
- `reset_button_n` input 1: raw push-button, low = pressed, asynchronous, bouncy.
- `rst` output 1: system reset, active-high, registered.
- `rst_release` output 1: one-cycle pulse on the edge where `rst` falls.
- `button_pressed` output 1: debounced button level, 1 = pressed.
- `reset_count` output 8: number of button-initiated resets, saturating at 255.

## Operation
- `rst_n` low (asynchronous):
  - state → HOLD; `rst`=1, `rst_release`=0, `button_pressed`=0, `reset_count`=0.
  - Hold and debounce counters = 0; synchroniser flops = 1 (released).
- Synchroniser: 2 flops on `reset_button_n`; the output is inverted to give `btn_sync` (1 = pressed).
- Debouncer:
  - Counter clears on any cycle where `btn_sync` == `button_pressed`.
  - Otherwise it increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `button_pressed` toggles and the counter clears.
  - Any single-cycle agreement restarts the count; glitches shorter than `DEBOUNCE_CYCLES` never propagate.
- FSM states: HOLD, RUN, PRESSED.
  - HOLD:
    - `rst`=1.
    - `button_pressed`=1 → PRESSED, hold counter cleared.
    - Else if hold counter == `HOLD_CYCLES`-1 → RUN.
    - Else hold counter increments.
  - RUN:
    - `rst`=0.
    - `button_pressed`=1 → PRESSED; `reset_count` increments unless it is 255.
  - PRESSED:
    - `rst`=1; hold counter held at 0.
    - `button_pressed`=0 → HOLD.
- A press during HOLD does not increment `reset_count`; only RUN→PRESSED counts.
- `rst` and `rst_release` are registered from the next-state logic, so both change on the same edge as the state.
- Hold counter width is $clog2(`HOLD_CYCLES`); debounce counter width is $clog2(`DEBOUNCE_CYCLES`+1).

## Timing
- After `rst_n` deasserts:
  - `rst` falls at exactly the `HOLD_CYCLES`-th rising edge, provided the button is released throughout.
  - `rst_release` is high for the cycle that follows that edge.
- Press latency: `button_pressed` rises `DEBOUNCE_CYCLES`+2 edges after a clean low level on `reset_button_n` (2 synchroniser edges plus the debounce count). `rst` rises 1 edge after that.
- Release latency: `rst` falls `DEBOUNCE_CYCLES`+2+`HOLD_CYCLES` edges after a clean high level on `reset_button_n`.
- Simultaneous hold-counter terminal and debounced press in HOLD: the press wins → PRESSED, and `rst` stays 1.
- `rst_n` asserted at any point, including mid-debounce or mid-hold: all state clears immediately. A held button then re-debounces from 0 after `rst_n` release.
- `rst_release` is never asserted while `rst_n` is low or in two consecutive cycles.

## Structure
- Shared package `retro_pkg`: FSM state enum `rst_state_t` {HOLD, RUN, PRESSED}, plus constant `CLK_HZ` = 25_000_000 for deriving the parameter defaults.
- Sub-module `button_debounce`, instantiated once. It holds the 2-flop synchroniser and the debounce counter, with parameter `DEBOUNCE_CYCLES`, input `raw_n`, and output `pressed`. It is reusable for other board buttons.

## Test plan
Parameters for all benches: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8.
- **Power-on:** `rst_n` low 3 cycles, then high, button released → `rst`=1 through edge 7 and 0 from edge 8; `rst_release` pulses exactly once; `reset_count`=0.
- **Button press from RUN:** `reset_button_n` low for 20 cycles → `button_pressed` rises 6 edges after the fall and `rst` rises 1 edge later; `reset_count`=1. After release, `rst` falls 6+8 edges after the rise of `reset_button_n`.
- **Bounce rejection:** `reset_button_n` toggles every 2 cycles for 40 cycles while in RUN → `button_pressed` stays 0, `rst` stays 0, `reset_count` stays 0.
- **Press during HOLD:** press held from `rst_n` release → stays in PRESSED; `rst` stays 1; `reset_count`=0. After release, `rst` falls 14 edges later.
- **Mid-operation async reset:** assert `rst_n` low mid-debounce (counter=2) and mid-hold (counter=5) → outputs reach their reset values without a clock edge; the sequence after release matches the power-on case.
- **Saturation:** 260 press/release cycles → `reset_count`=255 and it never wraps.

Source files
------------

// File: rtl/retro_pkg.sv
// retro_pkg: shared board constants and the reset sequencer state type.
package retro_pkg;
  localparam int CLK_HZ = 25_000_000;
  typedef enum logic [1:0] {HOLD, RUN, PRESSED} rst_state_t;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus stability counter for an active-low push-button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic raw_n,
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic btn_sync;
  assign btn_sync = ~sync[1];
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      cnt <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], raw_n};
      if (btn_sync == pressed) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        pressed <= ~pressed;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: turns power-on reset and a debounced push-button into a clean system reset
// with minimum hold time, a release strobe and a saturating press counter.
module reset_sequencer
  import retro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int HOLD_CYCLES = CLK_HZ / 10_000
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic       reset_button_n,
  output logic       rst,
  output logic       rst_release,
  output logic       button_pressed,
  output logic [7:0] reset_count
);
  localparam int HW = $clog2(HOLD_CYCLES);
  rst_state_t state;
  logic [HW-1:0] hold_cnt;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_25mhz(clk_25mhz),
    .rst_n(rst_n),
    .raw_n(reset_button_n),
    .pressed(button_pressed)
  );
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      state <= HOLD;
      hold_cnt <= '0;
      rst <= 1'b1;
      rst_release <= 1'b0;
      reset_count <= 8'd0;
    end else begin
      rst_release <= 1'b0;
      case (state)
        HOLD:
          if (button_pressed) begin
            state <= PRESSED;
            hold_cnt <= '0;
          end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state <= RUN;
            rst <= 1'b0;
            rst_release <= 1'b1;
          end else hold_cnt <= hold_cnt + HW'(1);
        RUN:
          if (button_pressed) begin
            state <= PRESSED;
            rst <= 1'b1;
            hold_cnt <= '0;
            if (reset_count != 8'hff) reset_count <= reset_count + 8'd1;
          end
        PRESSED:
          // The release cycle already counts as the first hold cycle.
          if (!button_pressed) begin
            state <= HOLD;
            hold_cnt <= HW'(1);
          end else hold_cnt <= '0;
        default: state <= HOLD;
      endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed stimulus against a cause/deadline reference model,
// scoreboarded per clock cycle.
module tb_reset_sequencer;
  localparam int D = 4;
  localparam int H = 8;
  typedef struct {
    logic r;
    logic rel;
    logic p;
    int c;
  } exp_t;
  logic clk_25mhz = 1'b0;
  logic rst_n = 1'b0;
  logic reset_button_n = 1'b1;
  logic rst, rst_release, button_pressed;
  logic [7:0] reset_count;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  bit bsq[$];
  int k, last_cause, last_tog, mc, pulses;
  bit mp, mr, raw1, raw2;
  reset_sequencer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk_25mhz(clk_25mhz),
    .rst_n(rst_n),
    .reset_button_n(reset_button_n),
    .rst(rst),
    .rst_release(rst_release),
    .button_pressed(button_pressed),
    .reset_count(reset_count)
  );
  always #5 clk_25mhz = ~clk_25mhz;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: rst stays high until H edges after the last edge that saw a cause (POR or debounced press).
  task automatic model_step();
    bit pre, rn, rel, agree;
    if (!rst_n) begin
      k = 0; last_cause = 0; last_tog = 0; mc = 0;
      mp = 0; mr = 1; raw1 = 1; raw2 = 1;
      bsq.delete();
      q.delete();
      q.push_back('{1'b1, 1'b0, 1'b0, 0});
    end else begin
      k++;
      bsq.push_back(!raw2);
      if (bsq.size() > D) void'(bsq.pop_front());
      raw2 = raw1;
      raw1 = reset_button_n;
      pre = mp;
      if (pre) last_cause = k;
      rn = (k - last_cause) < H;
      if (pre && !mr && mc < 255) mc++;
      rel = mr && !rn;
      mr = rn;
      if (k - last_tog >= D) begin
        agree = 0;
        foreach (bsq[i]) if (bsq[i] == mp) agree = 1;
        if (!agree) begin
          mp = !mp;
          last_tog = k;
        end
      end
      q.push_back('{mr, rel, mp, mc});
    end
  endtask
  initial forever begin
    @(posedge clk_25mhz or negedge rst_n);
    model_step();
  end
  initial forever begin
    exp_t e;
    @(negedge clk_25mhz);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rst", int'(rst), int'(e.r));
      chk("rst_release", int'(rst_release), int'(e.rel));
      chk("button_pressed", int'(button_pressed), int'(e.p));
      chk("reset_count", int'(reset_count), e.c);
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge clk_25mhz);
    #2;
  endtask
  task automatic async_reset_check(string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst"}, int'(rst), 1);
    chk({tag, "_release"}, int'(rst_release), 0);
    chk({tag, "_pressed"}, int'(button_pressed), 0);
    chk({tag, "_count"}, int'(reset_count), 0);
  endtask
  initial begin
    cyc(3);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      pulses += int'(rst_release);
    end
    chk("poweron_release_pulses", pulses, 1);
    reset_button_n = 1'b0;
    cyc(20);
    reset_button_n = 1'b1;
    cyc(30);
    for (int i = 0; i < 20; i++) begin
      reset_button_n = ~reset_button_n;
      cyc(2);
    end
    reset_button_n = 1'b1;
    cyc(20);
    for (int i = 0; i < 30; i++) begin
      reset_button_n = 1'($urandom_range(0, 1));
      cyc(int'($urandom_range(1, 12)));
    end
    reset_button_n = 1'b1;
    cyc(30);
    rst_n = 1'b0;
    reset_button_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(30);
    reset_button_n = 1'b1;
    cyc(30);
    reset_button_n = 1'b0;
    cyc(4);
    async_reset_check("mid_debounce");
    cyc(2);
    rst_n = 1'b1;
    cyc(25);
    reset_button_n = 1'b1;
    cyc(30);
    async_reset_check("pre_hold");
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    async_reset_check("mid_hold");
    cyc(2);
    rst_n = 1'b1;
    cyc(25);
    for (int i = 0; i < 260; i++) begin
      reset_button_n = 1'b0;
      cyc(8);
      reset_button_n = 1'b1;
      cyc(16);
    end
    cyc(5);
    chk("saturated_count", int'(reset_count), 255);
    chk("scoreboard_drained", q.size() <= 1 ? 1 : 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
